// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic {
    MEM_PORT_IF = 1'b0,
    MEM_PORT_LS = 1'b1
  } mem_port_t;

  typedef struct packed {
    logic      valid;
    mem_port_t port;
    logic      err;
  } mem_resp_t;

  function automatic mem_port_t other_port(input mem_port_t p);
    if (p == MEM_PORT_IF) begin
      return MEM_PORT_LS;
    end else begin
      return MEM_PORT_IF;
    end
  endfunction

endpackage

// File: rtl/round_robin_arbiter_2.sv
// Two-way round-robin arbiter; index 0 is the fetch port, index 1 the load/store port.
module round_robin_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [0:1] req,
  input  logic       advance,
  output logic [0:1] grant
);

  mem_port_t last_grant_q;
  mem_port_t last_grant_d;

  // On a tie the port that did not win last time takes the slot.
  always_comb begin
    grant = 2'b00;
    if (rst) begin
      grant = 2'b00;
    end else if (req[0] && req[1]) begin
      if (other_port(last_grant_q) == MEM_PORT_LS) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = req;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      if (grant[1]) begin
        last_grant_d = MEM_PORT_LS;
      end else begin
        last_grant_d = MEM_PORT_IF;
      end
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= MEM_PORT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one byte-writable word memory between the fetch and load/store ports,
// returning each granted access one cycle later on its own port.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter  int MEMORY_DEPTH = 32768,
  localparam int ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [0:31]       if_address,
  output logic              if_resp_valid,
  output logic              if_resp_err,
  output logic [0:31]       if_read_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [0:31]       ls_address,
  input  logic [0:3]        ls_wen,
  input  logic [0:31]       ls_write_data,
  output logic              ls_resp_valid,
  output logic              ls_resp_err,
  output logic [0:31]       ls_read_data,
  output logic [0:ADDR_W-1] mem_address,
  output logic [0:3]        mem_wen,
  output logic [0:31]       mem_write_data,
  input  logic [0:31]       mem_read_data
);

  logic [0:1]        req;
  logic [0:1]        grant;
  logic              grant_any;
  logic              if_oor;
  logic              ls_oor;
  logic [0:ADDR_W-1] if_word;
  logic [0:ADDR_W-1] ls_word;
  logic [0:ADDR_W-1] mem_address_d;
  logic [0:ADDR_W-1] mem_address_q;
  mem_resp_t         resp_d;
  mem_resp_t         resp_q;
  logic              unused_byte_offset;

  assign req       = {if_req_valid, ls_req_valid};
  assign grant_any = grant[0] | grant[1];

  round_robin_arbiter_2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (grant_any),
    .grant   (grant)
  );

  assign if_req_ready = grant[0];
  assign ls_req_ready = grant[1];

  // Byte offset bits never reach the memory; lanes come from the write enables.
  assign if_word            = if_address[30-ADDR_W:29];
  assign ls_word            = ls_address[30-ADDR_W:29];
  assign if_oor             = |if_address[0:29-ADDR_W];
  assign ls_oor             = |ls_address[0:29-ADDR_W];
  assign unused_byte_offset = ^{if_address[30:31], ls_address[30:31]};

  always_comb begin
    mem_address_d = mem_address_q;
    mem_wen       = 4'b0000;
    resp_d        = '0;
    if (grant_any) begin
      resp_d.valid = 1'b1;
      if (grant[1]) begin
        mem_address_d = ls_word;
        resp_d.port   = MEM_PORT_LS;
        resp_d.err    = ls_oor;
        if (!ls_oor) begin
          mem_wen = ls_wen;
        end else begin
          mem_wen = 4'b0000;
        end
      end else begin
        mem_address_d = if_word;
        resp_d.port   = MEM_PORT_IF;
        resp_d.err    = if_oor;
      end
    end else begin
      mem_address_d = mem_address_q;
    end
  end

  assign mem_address    = rst ? '0 : mem_address_d;
  assign mem_write_data = ls_write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_address_q <= '0;
      resp_q        <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      resp_q        <= resp_d;
    end
  end

  // A response whose cycle coincides with reset is suppressed.
  assign if_resp_valid = resp_q.valid && (resp_q.port == MEM_PORT_IF) && !rst;
  assign ls_resp_valid = resp_q.valid && (resp_q.port == MEM_PORT_LS) && !rst;
  assign if_resp_err   = if_resp_valid && resp_q.err;
  assign ls_resp_err   = ls_resp_valid && resp_q.err;
  assign if_read_data  = resp_q.err ? 32'h0000_0000 : mem_read_data;
  assign ls_read_data  = resp_q.err ? 32'h0000_0000 : mem_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a reference memory and response scoreboard.
module tb_memory_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [0:31]   if_address = 32'h0;
  logic          if_resp_valid;
  logic          if_resp_err;
  logic [0:31]   if_read_data;
  logic          ls_req_valid = 1'b0;
  logic          ls_req_ready;
  logic [0:31]   ls_address = 32'h0;
  logic [0:3]    ls_wen = 4'b0000;
  logic [0:31]   ls_write_data = 32'h0;
  logic          ls_resp_valid;
  logic          ls_resp_err;
  logic [0:31]   ls_read_data;
  logic [0:AW-1] mem_address;
  logic [0:3]    mem_wen;
  logic [0:31]   mem_write_data;
  logic [0:31]   mem_read_data;

  memory_arbiter #(.MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_address(if_address),
    .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err), .if_read_data(if_read_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_address(ls_address),
    .ls_wen(ls_wen), .ls_write_data(ls_write_data),
    .ls_resp_valid(ls_resp_valid), .ls_resp_err(ls_resp_err), .ls_read_data(ls_read_data),
    .mem_address(mem_address), .mem_wen(mem_wen), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Attached single-port memory: registered read, read-before-write, byte lanes.
  logic [0:31] mem [0:DEPTH-1];
  always @(posedge clk) begin
    mem_read_data <= mem[mem_address];
    for (int b = 0; b < 4; b++) begin
      if (mem_wen[b] === 1'b1) mem[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  typedef struct {
    logic        port;
    logic        err;
    logic [0:31] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [0:31] ref_mem [0:DEPTH-1];
  logic        tb_last = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        obs_if_ready, obs_ls_ready, obs_if_v, obs_ls_v, obs_if_err, obs_ls_err;
  logic [0:3]  obs_mem_wen;
  logic [0:31] obs_if_data, obs_ls_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every response must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (if_resp_valid === 1'b1 || ls_resp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got if_v=%b ls_v=%b, expected no response", if_resp_valid, ls_resp_valid);
      end else begin
        sb_e = sb_q.pop_front();
        if (sb_e.due != cyc
            || (sb_e.port ? ls_resp_valid : if_resp_valid) !== 1'b1
            || (sb_e.port ? if_resp_valid : ls_resp_valid) !== 1'b0
            || (sb_e.port ? ls_resp_err : if_resp_err) !== sb_e.err
            || (sb_e.port ? ls_read_data : if_read_data) !== sb_e.data) begin
          failures++;
          $display("FAIL sb_resp: got cyc=%0d if_v=%b ls_v=%b if_err=%b ls_err=%b if_d=%h ls_d=%h, expected cyc=%0d port=%b err=%b data=%h",
                   cyc, if_resp_valid, ls_resp_valid, if_resp_err, ls_resp_err, if_read_data, ls_read_data,
                   sb_e.due, sb_e.port, sb_e.err, sb_e.data);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      checks++;
      failures++;
      $display("FAIL sb_missing: got no response, expected port=%b data=%h", sb_q[0].port, sb_q[0].data);
      void'(sb_q.pop_front());
    end
  end

  task automatic preload(input int w, input logic [0:31] d);
    mem[w]     = d;
    ref_mem[w] = d;
  endtask

  // One clock of stimulus: predicts the grant, checks the handshake and memory drive.
  task automatic run_cycle(input logic ifv, input logic [0:31] ifa, input logic lsv,
                           input logic [0:31] lsa, input logic [0:3] wen, input logic [0:31] wd);
    logic          g_if, g_ls, oor;
    logic [0:31]   a;
    logic [0:AW-1] w;
    logic [0:3]    exp_wen;
    exp_t          ne;
    if_req_valid = ifv; if_address = ifa;
    ls_req_valid = lsv; ls_address = lsa; ls_wen = wen; ls_write_data = wd;
    @(negedge clk);
    obs_if_ready = if_req_ready; obs_ls_ready = ls_req_ready; obs_mem_wen = mem_wen;
    obs_if_v = if_resp_valid; obs_ls_v = ls_resp_valid;
    obs_if_err = if_resp_err; obs_ls_err = ls_resp_err;
    obs_if_data = if_read_data; obs_ls_data = ls_read_data;
    g_if = !rst && ifv && (!lsv || tb_last);
    g_ls = !rst && lsv && (!ifv || !tb_last);
    checks++;
    if (if_req_ready !== g_if || ls_req_ready !== g_ls) begin
      failures++;
      $display("FAIL ready: got if=%b ls=%b, expected if=%b ls=%b", if_req_ready, ls_req_ready, g_if, g_ls);
    end
    a       = g_ls ? lsa : ifa;
    oor     = (a >> 12) != 32'h0;
    w       = AW'(a >> 2);
    exp_wen = (g_ls && !oor) ? wen : 4'b0000;
    checks++;
    if (mem_wen !== exp_wen) begin
      failures++;
      $display("FAIL mem_wen: got %b, expected %b", mem_wen, exp_wen);
    end
    if (g_if || g_ls) begin
      checks++;
      if (mem_address !== w) begin
        failures++;
        $display("FAIL mem_address: got %h, expected %h", mem_address, w);
      end
      ne.port = g_ls; ne.err = oor; ne.data = oor ? 32'h0 : ref_mem[w]; ne.due = cyc + 1;
      sb_q.push_back(ne);
      if (g_ls && !oor) begin
        for (int b = 0; b < 4; b++) if (wen[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end
      tb_last = g_ls;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    run_cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tb_last = 1'b0; sb_q.delete();
    idle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_cycle(1'b1, 32'h40, 1'b1, 32'h80, 4'b1111, 32'hFFFF_FFFF);
      checks++;
      if (obs_if_ready !== 1'b0 || obs_ls_ready !== 1'b0 || obs_if_v !== 1'b0 || obs_ls_v !== 1'b0
          || obs_if_err !== 1'b0 || obs_ls_err !== 1'b0 || obs_mem_wen !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs: got rdy=%b%b v=%b%b err=%b%b wen=%b, expected all 0",
                 obs_if_ready, obs_ls_ready, obs_if_v, obs_ls_v, obs_if_err, obs_ls_err, obs_mem_wen);
      end
    end
    @(negedge clk);
    checks++;
    if (mem_address !== '0) begin
      failures++;
      $display("FAIL reset_mem_address: got %h, expected 0", mem_address);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    run_cycle(1'b0, 32'h0, 1'b1, 32'h40, 4'b0000, 32'h0);
    idle();
    checks++;
    if (obs_ls_v !== 1'b1 || obs_ls_data !== 32'hDEAD_BEEF || obs_if_v !== 1'b0) begin
      failures++;
      $display("FAIL single_load: got ls_v=%b data=%h if_v=%b, expected 1 deadbeef 0", obs_ls_v, obs_ls_data, obs_if_v);
    end
  endtask

  task automatic test_byte_store();
    run_cycle(1'b0, 32'h0, 1'b1, 32'h80, 4'b0100, 32'h00AB_0000);
    run_cycle(1'b0, 32'h0, 1'b1, 32'h80, 4'b0000, 32'h0);
    checks++;
    if (obs_ls_v !== 1'b1 || obs_ls_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL store_prewrite: got v=%b data=%h, expected 1 11223344", obs_ls_v, obs_ls_data);
    end
    idle();
    checks++;
    if (obs_ls_data !== 32'h11AB_3344) begin
      failures++;
      $display("FAIL store_merge: got %h, expected 11ab3344", obs_ls_data);
    end
  endtask

  task automatic test_contention();
    logic [3:0] seq;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, 32'h100, 1'b1, 32'h200, 4'b0000, 32'h0);
      seq[3-k] = obs_ls_ready;
      if (k > 0) begin
        checks++;
        if ((obs_if_v | obs_ls_v) !== 1'b1) begin
          failures++;
          $display("FAIL contention_bubble: got no response at step %0d, expected one", k);
        end
      end
    end
    idle();
    checks++;
    if (seq !== 4'b1010 || obs_if_v !== 1'b1) begin
      failures++;
      $display("FAIL contention_order: got ls grants %b last_if_v=%b, expected 1010 1", seq, obs_if_v);
    end
  endtask

  task automatic test_out_of_range();
    run_cycle(1'b0, 32'h0, 1'b1, 32'h1000, 4'b1111, 32'hFFFF_FFFF);
    checks++;
    if (obs_mem_wen !== 4'b0000) begin
      failures++;
      $display("FAIL oor_wen: got %b, expected 0000", obs_mem_wen);
    end
    run_cycle(1'b0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    checks++;
    if (obs_ls_err !== 1'b1 || obs_ls_data !== 32'h0) begin
      failures++;
      $display("FAIL oor_resp: got err=%b data=%h, expected 1 0", obs_ls_err, obs_ls_data);
    end
    run_cycle(1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'b0000, 32'h0);
    checks++;
    if (obs_ls_data !== 32'hCAFE_F00D || obs_ls_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_mem_unchanged: got %h err=%b, expected cafef00d 0", obs_ls_data, obs_ls_err);
    end
    run_cycle(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 4'b0000, 32'h0);
    checks++;
    if (obs_if_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_if_msb: got err=%b, expected 1", obs_if_err);
    end
    idle();
    checks++;
    if (obs_if_err !== 1'b0 || obs_if_v !== 1'b1) begin
      failures++;
      $display("FAIL last_word_in_range: got v=%b err=%b, expected 1 0", obs_if_v, obs_if_err);
    end
  endtask

  task automatic test_reset_mid_access();
    run_cycle(1'b1, 32'h40, 1'b0, 32'h0, 4'b0000, 32'h0);
    rst = 1'b1; tb_last = 1'b0; sb_q.delete();
    run_cycle(1'b1, 32'h44, 1'b1, 32'h48, 4'b1111, 32'hFFFF_FFFF);
    checks++;
    if (obs_if_v !== 1'b0 || obs_if_ready !== 1'b0 || obs_ls_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop: got if_v=%b rdy=%b%b, expected 0 00", obs_if_v, obs_if_ready, obs_ls_ready);
    end
    rst = 1'b0;
    run_cycle(1'b1, 32'h44, 1'b1, 32'h48, 4'b0000, 32'h0);
    checks++;
    if (obs_ls_ready !== 1'b1 || obs_if_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_tie: got if=%b ls=%b, expected 0 1", obs_if_ready, obs_ls_ready);
    end
    run_cycle(1'b1, 32'h44, 1'b0, 32'h0, 4'b0000, 32'h0);
    idle();
  endtask

  task automatic test_fetch_isolation();
    run_cycle(1'b1, 32'h40, 1'b0, 32'h80, 4'b1111, 32'hFFFF_FFFF);
    checks++;
    if (obs_mem_wen !== 4'b0000 || obs_if_ready !== 1'b1) begin
      failures++;
      $display("FAIL fetch_wen: got wen=%b rdy=%b, expected 0000 1", obs_mem_wen, obs_if_ready);
    end
    idle();
    checks++;
    if (obs_if_v !== 1'b1 || obs_if_data !== 32'hDEAD_BEEF || obs_ls_v !== 1'b0) begin
      failures++;
      $display("FAIL fetch_data: got v=%b data=%h ls_v=%b, expected 1 deadbeef 0", obs_if_v, obs_if_data, obs_ls_v);
    end
  endtask

  task automatic test_back_to_back();
    logic        ipend, lpend;
    logic [0:31] ia, la, ld;
    logic [0:3]  lw;
    ipend = 1'b0; lpend = 1'b0; ia = 32'h0; la = 32'h0; ld = 32'h0; lw = 4'b0000;
    for (int n = 0; n < 300; n++) begin
      if (!ipend && $urandom_range(0, 9) < 7) begin
        ipend = 1'b1;
        ia = 32'($urandom_range(0, 32'h10FF));
      end
      if (!lpend && $urandom_range(0, 9) < 7) begin
        lpend = 1'b1;
        la = 32'($urandom_range(0, 32'h10FF));
        if ($urandom_range(0, 15) == 0) la = la | 32'h4000_0000;
        lw = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        ld = $urandom;
      end
      run_cycle(ipend, ia, lpend, la, lw, ld);
      if (obs_if_ready === 1'b1) ipend = 1'b0;
      if (obs_ls_ready === 1'b1) lpend = 1'b0;
    end
    idle();
    idle();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) preload(i, 32'(i) * 32'h9E37_79B1);
    preload(32'h10, 32'hDEAD_BEEF);
    preload(32'h20, 32'h1122_3344);
    preload(32'h0, 32'hCAFE_F00D);
    test_reset();
    test_single_load();
    test_byte_store();
    test_contention();
    test_out_of_range();
    test_reset_mid_access();
    test_fetch_isolation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
